puf_challenge_ctrl: RTL and testbench

PUF_CHALLENGE_CTRL -- requirements
Module: puf_challenge_ctrl

---
 rtl/puf_challenge_ctrl.sv | 151 +++++++++++++++
 tb/tb_puf_challenge_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_ctrl.sv
// Purpose : drives an arbiter-PUF delay chain; walks an LFSR challenge, races an edge per bit, collects RESP_BITS arbiter bits.
// Latency : resp_valid rises 1 + RESP_BITS*(2*SETTLE_CYCLES+1) cycles after the edge that accepts start.
// Backpr. : DONE holds resp_valid/resp_data until resp_ready; start is only looked at in IDLE.
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   start, seed[63:0]     run request and initial challenge (seed 0 replaced by 1)
//   challenge[63:0]       stage select lines to the delay chain
//   launch                edge injected at the chain head (registered, glitch-free)
//   arb_in                arbiter decision at the chain tail
//   resp_data/valid/ready collected response and its handshake
//   busy                  high whenever not IDLE
module puf_challenge_ctrl #(
    parameter int RESP_BITS     = 32,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [63:0]          seed,
    output logic [63:0]          challenge,
    output logic                 launch,
    input  logic                 arb_in,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RISE   = 3'd2,
        SAMPLE = 3'd3,
        FALL   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [6:0] BITS_TOTAL  = 7'(RESP_BITS);

    state_t                 state_q, state_d;
    logic [63:0]            challenge_q, challenge_d;
    logic [RESP_BITS-1:0]   resp_q, resp_d;
    logic [6:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             settle_cnt_q, settle_cnt_d;
    logic                   launch_q, launch_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            challenge_q  <= 64'h0;
            resp_q       <= '0;
            bit_cnt_q    <= 7'd0;
            settle_cnt_q <= 8'd0;
            launch_q     <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            challenge_q  <= challenge_d;
            resp_q       <= resp_d;
            bit_cnt_q    <= bit_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            launch_q     <= launch_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        challenge_d  = challenge_q;
        resp_d       = resp_q;
        bit_cnt_d    = bit_cnt_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    // An all-zero LFSR state never leaves zero.
                    challenge_d  = (seed == 64'h0) ? 64'h1 : seed;
                    resp_d       = '0;
                    bit_cnt_d    = 7'd0;
                    settle_cnt_d = 8'd0;
                end
            end
            LOAD: begin
                state_d      = RISE;
                settle_cnt_d = 8'd0;
            end
            RISE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = SAMPLE;
                    settle_cnt_d = 8'd0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                // First bit shifts all the way up to the MSB by the end of the run.
                resp_d       = (resp_q << 1) | RESP_BITS'(arb_in);
                bit_cnt_d    = bit_cnt_q + 7'd1;
                state_d      = FALL;
                settle_cnt_d = 8'd0;
            end
            FALL: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = 8'd0;
                    if (bit_cnt_q == BITS_TOTAL) begin
                        state_d = DONE;
                    end else begin
                        // Advance only here, while the chain is quiet (launch low).
                        challenge_d = {challenge_q[62:0],
                                       challenge_q[63] ^ challenge_q[62] ^
                                       challenge_q[60] ^ challenge_q[59]};
                        state_d     = RISE;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered so launch
    // reaching the delay chain cannot glitch on state decode.
    always_comb begin
        launch_d = (state_d == RISE) || (state_d == SAMPLE);
        valid_d  = (state_d == DONE);
        busy_d   = (state_d != IDLE);
    end

    assign challenge  = challenge_q;
    assign launch     = launch_q;
    assign resp_data  = resp_q;
    assign resp_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
module tb_puf_challenge_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [63:0] seed;
    logic        arb_in;
    logic        resp_ready;

    logic [63:0] ch_a, ch_b;
    logic        l_a, l_b, rv_a, rv_b, busy_a, busy_b;
    logic [3:0]  rd_a;
    logic [31:0] rd_b;

    int n_checks;
    int n_fail;

    // Observation mux: use_b selects the default-parameter instance.
    bit          use_b;
    logic [63:0] ch_s, rd_s;
    logic        l_s, rv_s, busy_s;

    // Filled by run()
    logic [63:0] chal_log [0:63];
    int          hi_log [0:63];
    int          nl;
    int          lat;
    int          stable_err;

    puf_challenge_ctrl #(.RESP_BITS(4), .SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .seed(seed),
        .challenge(ch_a), .launch(l_a), .arb_in(arb_in),
        .resp_data(rd_a), .resp_valid(rv_a), .resp_ready(resp_ready), .busy(busy_a)
    );

    puf_challenge_ctrl dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .seed(seed),
        .challenge(ch_b), .launch(l_b), .arb_in(arb_in),
        .resp_data(rd_b), .resp_valid(rv_b), .resp_ready(resp_ready), .busy(busy_b)
    );

    always_comb begin
        ch_s   = use_b ? ch_b : ch_a;
        l_s    = use_b ? l_b : l_a;
        rv_s   = use_b ? rv_b : rv_a;
        busy_s = use_b ? busy_b : busy_a;
        rd_s   = use_b ? {32'h0, rd_b} : {60'h0, rd_a};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] adv(input logic [63:0] c);
        return {c[62:0], c[63] ^ c[62] ^ c[60] ^ c[59]};
    endfunction

    // Start a run and follow it until resp_valid (or timeout). pat[nbits-1]
    // is the bit for the first SAMPLE. arb_in is random whenever launch is low.
    task automatic run(input bit ub, input logic [63:0] sd, input logic [63:0] pat, input int nbits);
        bit prev_l;
        int k;
        use_b = ub;
        @(negedge clk);
        seed = sd;
        if (ub) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        k = 0; nl = 0; prev_l = 1'b0; stable_err = 0;
        while (!rv_s && k < 5000) begin
            if (l_s && !prev_l && nl < 64) begin
                chal_log[nl] = ch_s;
                hi_log[nl]   = 0;
                nl++;
            end
            if (l_s && nl > 0) begin
                hi_log[nl-1]++;
                if (ch_s !== chal_log[nl-1]) stable_err++;
                if (nl <= nbits) arb_in = pat[nbits-nl];
            end else begin
                arb_in = 1'($urandom_range(0, 1));
            end
            prev_l = l_s;
            @(negedge clk);
            k++;
        end
        lat = k;
        n_checks++;
        if (k >= 5000) begin
            n_fail++;
            $display("FAIL run_timeout: resp_valid never rose (waited %0d cycles)", k);
        end
    endtask

    task automatic ack;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_checks++;
        if (rv_s !== 1'b0 || busy_s !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_to_idle: valid=%b busy=%b, want 0 0", rv_s, busy_s);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ch_a !== 64'h0) begin n_fail++; $display("FAIL reset_challenge: got %h want 0", ch_a); end
        n_checks++;
        if (l_a !== 1'b0) begin n_fail++; $display("FAIL reset_launch: got %b want 0", l_a); end
        n_checks++;
        if (rd_a !== 4'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", rd_a); end
        n_checks++;
        if (rv_a !== 1'b0 || rv_b !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b%b want 00", rv_a, rv_b); end
        n_checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b%b want 00", busy_a, busy_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run(1'b0, 64'h1, 64'hF, 4);
        n_checks++;
        if (lat != 13) begin n_fail++; $display("FAIL basic_latency: got %0d want 13", lat); end
        n_checks++;
        if (rd_s !== 64'hF) begin n_fail++; $display("FAIL basic_resp_data: got %h want f", rd_s); end
        n_checks++;
        if (nl != 4) begin n_fail++; $display("FAIL basic_launch_pulses: got %0d want 4", nl); end
        n_checks++;
        if (chal_log[0] !== 64'h1 || chal_log[1] !== 64'h2 || chal_log[2] !== 64'h4 || chal_log[3] !== 64'h8) begin
            n_fail++;
            $display("FAIL basic_challenge_seq: got %h %h %h %h want 1 2 4 8",
                     chal_log[0], chal_log[1], chal_log[2], chal_log[3]);
        end
        n_checks++;
        if (stable_err != 0) begin n_fail++; $display("FAIL basic_challenge_stable: %0d changes while launch high, want 0", stable_err); end
        n_checks++;
        if (busy_s !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done: got %b want 1", busy_s); end
        ack();
    endtask

    task automatic test_zero_seed;
        run(1'b0, 64'h0, 64'h0, 4);
        n_checks++;
        if (chal_log[0] !== 64'h1) begin n_fail++; $display("FAIL zero_seed_first: got %h want 1", chal_log[0]); end
        n_checks++;
        if (rd_s !== 64'h0) begin n_fail++; $display("FAIL zero_seed_resp: got %h want 0", rd_s); end
        ack();
    endtask

    task automatic test_msb_seed;
        run(1'b0, 64'h8000_0000_0000_0000, 64'h6, 4);
        n_checks++;
        if (chal_log[0] !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL msb_seed_first: got %h want 8000000000000000", chal_log[0]); end
        n_checks++;
        if (chal_log[1] !== 64'h1) begin n_fail++; $display("FAIL msb_seed_second: got %h want 1", chal_log[1]); end
        n_checks++;
        if (chal_log[2] !== 64'h2) begin n_fail++; $display("FAIL msb_seed_third: got %h want 2", chal_log[2]); end
        n_checks++;
        if (rd_s !== 64'h6) begin n_fail++; $display("FAIL msb_seed_resp: got %h want 6", rd_s); end
        ack();
    endtask

    task automatic test_pattern_hold;
        run(1'b0, 64'h1, 64'hB, 4);
        n_checks++;
        if (rd_s !== 64'hB) begin n_fail++; $display("FAIL pattern_resp: got %h want b", rd_s); end
        seed = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 5; i++) begin
            start_a = (i % 2 == 0);
            @(negedge clk);
            n_checks++;
            if (rv_s !== 1'b1 || rd_s !== 64'hB || ch_s !== 64'h8) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b data=%h chal=%h want 1 b 8", i, rv_s, rd_s, ch_s);
            end
        end
        // start together with resp_ready: only the handshake happens
        start_a = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        resp_ready = 1'b0;
        n_checks++;
        if (busy_s !== 1'b0 || rv_s !== 1'b0) begin n_fail++; $display("FAIL start_with_ready: busy=%b valid=%b want 0 0", busy_s, rv_s); end
        @(negedge clk);
        n_checks++;
        if (busy_s !== 1'b0 || ch_s !== 64'h8) begin n_fail++; $display("FAIL start_with_ready_idle: busy=%b chal=%h want 0 8", busy_s, ch_s); end
    endtask

    task automatic test_reset_midrun;
        use_b = 1'b0;
        @(negedge clk);
        seed = 64'h1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (l_s !== 1'b1 || ch_s !== 64'h2) begin n_fail++; $display("FAIL midrun_second_rise: launch=%b chal=%h want 1 2", l_s, ch_s); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (l_s !== 1'b0 || busy_s !== 1'b0 || rv_s !== 1'b0 || ch_s !== 64'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: launch=%b busy=%b valid=%b chal=%h want 0 0 0 0", l_s, busy_s, rv_s, ch_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_checks++;
            if (rv_s !== 1'b0 || busy_s !== 1'b0) begin n_fail++; $display("FAIL midrun_no_partial%0d: valid=%b busy=%b want 0 0", i, rv_s, busy_s); end
        end
        run(1'b0, 64'h1, 64'h5, 4);
        n_checks++;
        if (lat != 13) begin n_fail++; $display("FAIL after_reset_latency: got %0d want 13", lat); end
        n_checks++;
        if (rd_s !== 64'h5) begin n_fail++; $display("FAIL after_reset_resp: got %h want 5", rd_s); end
        ack();
    endtask

    task automatic test_defaults;
        logic [63:0] c;
        int bad_hi;
        int bad_ch;
        run(1'b1, 64'hDEAD_BEEF_0123_4567, 64'h0000_0000_A5C3_0F96, 32);
        n_checks++;
        if (lat != 545) begin n_fail++; $display("FAIL default_latency: got %0d want 545", lat); end
        n_checks++;
        if (rd_s !== 64'h0000_0000_A5C3_0F96) begin n_fail++; $display("FAIL default_resp: got %h want a5c30f96", rd_s); end
        n_checks++;
        if (nl != 32) begin n_fail++; $display("FAIL default_pulses: got %0d want 32", nl); end
        bad_hi = 0;
        bad_ch = 0;
        c = 64'hDEAD_BEEF_0123_4567;
        for (int i = 0; i < 32; i++) begin
            if (hi_log[i] != 9) bad_hi++;
            if (chal_log[i] !== c) bad_ch++;
            c = adv(c);
        end
        n_checks++;
        if (bad_hi != 0) begin n_fail++; $display("FAIL default_launch_width: %0d bits not 9 cycles high (bit0=%0d)", bad_hi, hi_log[0]); end
        n_checks++;
        if (bad_ch != 0) begin n_fail++; $display("FAIL default_challenge_seq: %0d wrong challenges, want 0", bad_ch); end
        n_checks++;
        if (stable_err != 0) begin n_fail++; $display("FAIL default_challenge_stable: %0d changes while launch high, want 0", stable_err); end
        ack();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        use_b      = 1'b0;
        rst_n      = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        seed       = 64'h0;
        arb_in     = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_seed();
        test_msb_seed();
        test_pattern_hold();
        test_reset_midrun();
        test_defaults();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
